// File: rtl/adc_seq_pkg.sv
// adc_acq_sequencer shared types and constants.
// FSM state encoding, timing constants, command formatting.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CMD,
    CMD_WAIT
  } seq_state_t;

  localparam int MIN_PERIOD       = 2;
  localparam int CMD_GUARD_CYCLES = 2;

  function automatic logic [31:0] cmd_word(
    input logic [23:0] c
  );
    return {8'h00, c};
  endfunction

endpackage

// File: rtl/adc_acq_sequencer_if.sv
// Command-side stream bundle of the acquisition sequencer.
// master = sequencer side, slave = software/ADC side.
interface adc_acq_sequencer_if #(
  parameter int CMD_WIDTH = 24
);
  logic [CMD_WIDTH-1:0] s_cmd_tdata;
  logic                 s_cmd_tvalid;
  logic                 s_cmd_tready;
  logic [31:0]          m_axis_tdata;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;

  modport master (
    input  s_cmd_tdata,
    input  s_cmd_tvalid,
    output s_cmd_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    output s_cmd_tdata,
    output s_cmd_tvalid,
    input  s_cmd_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/adc_seq_timer.sv
// Loadable auto-reload down-counter for the trigger period.
// o_tick is high while the count sits at zero.
module adc_seq_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_reload,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  assign o_tick = (r_cnt == '0);

  // The load cycle already counts as one elapsed cycle of the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_reload - W'(1);
    end else if (i_en) begin
      r_cnt <= o_tick ? i_reload : r_cnt - W'(1);
    end
  end

endmodule

// File: rtl/adc_acq_sequencer.sv
// Periodic ADC trigger scheduler with command serialisation.
// Commands only go out between runs; skipped slots flag overrun.
module adc_acq_sequencer
  import adc_seq_pkg::*;
#(
  parameter int CNT_WIDTH = 32,
  parameter int CMD_WIDTH = 24
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [CNT_WIDTH-1:0] cfg_period,
  input  logic [CNT_WIDTH-1:0] cfg_num_samples,
  input  logic                 start,
  input  logic                 stop,
  adc_acq_sequencer_if.master  bus,
  input  logic                 adc_ready,
  output logic                 trigger_acq,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun,
  output logic [CNT_WIDTH-1:0] sample_cnt
);

  seq_state_t           r_state;
  seq_state_t           w_state_nxt;
  logic                 r_start_pend;
  logic                 w_pend_nxt;
  logic                 r_trig;
  logic                 w_trig_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_ovr;
  logic                 w_ovr_set;
  logic                 w_cnt_inc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_period;
  logic [CNT_WIDTH-1:0] r_num;
  logic [CMD_WIDTH-1:0] r_cmd;
  logic [1:0]           r_guard;
  logic [1:0]           w_guard_nxt;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_start_req;
  logic                 w_tick;
  logic [CNT_WIDTH-1:0] w_period_c;
  logic [CNT_WIDTH-1:0] w_reload;

  assign w_period_c =
    (cfg_period < CNT_WIDTH'(MIN_PERIOD)) ?
    CNT_WIDTH'(MIN_PERIOD) : cfg_period;

  assign w_reload = w_load ?
    (w_period_c - CNT_WIDTH'(1)) :
    (r_period - CNT_WIDTH'(1));

  assign w_start_req = (r_start_pend | start) & ~stop;

  adc_seq_timer #(
    .W(CNT_WIDTH)
  ) u_timer (
    .clk     (aclk),
    .rst     (areset),
    .i_load  (w_load),
    .i_en    (r_state == RUN),
    .i_reload(w_reload),
    .o_tick  (w_tick)
  );

  // Next-state and per-cycle control decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_trig_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    w_ovr_set   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_guard_nxt = r_guard;
    unique case (r_state)
      IDLE: begin
        if (bus.s_cmd_tvalid) begin
          w_accept    = 1'b1;
          w_state_nxt = CMD;
        end else if (w_start_req) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_trig && (r_num != '0) &&
                     (r_cnt == r_num)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          if (adc_ready) begin
            w_trig_nxt = 1'b1;
            w_cnt_inc  = 1'b1;
          end else begin
            w_ovr_set = 1'b1;
          end
        end
      end
      CMD: begin
        if (bus.m_axis_tready) begin
          w_guard_nxt = 2'(CMD_GUARD_CYCLES - 1);
          w_state_nxt = CMD_WAIT;
        end
      end
      CMD_WAIT: begin
        if (r_guard != 2'd0) begin
          w_guard_nxt = r_guard - 2'd1;
        end else if (adc_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pending start: stop beats start, RUN entry consumes it.
  always_comb begin
    w_pend_nxt = r_start_pend;
    if (stop) begin
      w_pend_nxt = 1'b0;
    end else if (w_load) begin
      w_pend_nxt = 1'b0;
    end else if (start) begin
      w_pend_nxt = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Run parameters, counters, pulses and the held command.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_start_pend <= 1'b0;
      r_trig       <= 1'b0;
      r_done       <= 1'b0;
      r_ovr        <= 1'b0;
      r_cnt        <= '0;
      r_period     <= CNT_WIDTH'(MIN_PERIOD);
      r_num        <= '0;
      r_cmd        <= '0;
      r_guard      <= 2'd0;
    end else begin
      r_start_pend <= w_pend_nxt;
      r_trig       <= w_trig_nxt;
      r_done       <= w_done_nxt;
      r_guard      <= w_guard_nxt;
      if (w_accept) begin
        r_cmd <= bus.s_cmd_tdata;
      end
      if (w_load) begin
        r_period <= w_period_c;
        r_num    <= cfg_num_samples;
        r_cnt    <= '0;
        r_ovr    <= 1'b0;
      end else begin
        if (w_cnt_inc && (r_cnt != '1)) begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        if (w_ovr_set) begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  assign trigger_acq       = r_trig;
  assign done              = r_done;
  assign overrun           = r_ovr;
  assign sample_cnt        = r_cnt;
  assign busy              = (r_state != IDLE);
  assign bus.s_cmd_tready  = w_accept & ~areset;
  assign bus.m_axis_tvalid = (r_state == CMD);
  assign bus.m_axis_tdata  = (r_state == CMD) ?
    cmd_word(r_cmd) : 32'h0;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Directed bench for adc_acq_sequencer.
// Cycle k starts 1 time unit after the k-th rising edge.
module tb_adc_acq_sequencer;

  logic        aclk;
  logic        areset;
  logic [31:0] cfg_period;
  logic [31:0] cfg_num_samples;
  logic        start;
  logic        stop;
  logic        adc_ready;
  logic        trigger_acq;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [31:0] sample_cnt;

  adc_acq_sequencer_if #(.CMD_WIDTH(24)) bus ();

  adc_acq_sequencer #(
    .CNT_WIDTH(32),
    .CMD_WIDTH(24)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .cfg_period     (cfg_period),
    .cfg_num_samples(cfg_num_samples),
    .start          (start),
    .stop           (stop),
    .bus            (bus),
    .adc_ready      (adc_ready),
    .trigger_acq    (trigger_acq),
    .busy           (busy),
    .done           (done),
    .overrun        (overrun),
    .sample_cnt     (sample_cnt)
  );

  int n_tot = 0;
  int n_bad = 0;
  int trig_q[$];
  int done_q[$];
  int rdy_c;
  int idle_c;
  bit cmd_sent;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_zero(input string p);
    check({p, "_trig"}, trigger_acq, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_ovr"}, overrun, 0);
    check({p, "_cnt"}, sample_cnt, 0);
    check({p, "_srdy"}, bus.s_cmd_tready, 0);
    check({p, "_mval"}, bus.m_axis_tvalid, 0);
    check({p, "_mdat"}, bus.m_axis_tdata, 0);
  endtask

  // start in cycle 0; adc_ready low in [lo_a,lo_b];
  // stop in cycle stop_c; command offered from cmd_c.
  task automatic run(
    input int p,
    input int n,
    input int cycles,
    input int lo_a,
    input int lo_b,
    input int stop_c,
    input int cmd_c
  );
    cfg_period      = p;
    cfg_num_samples = n;
    trig_q.delete();
    done_q.delete();
    rdy_c    = -1;
    cmd_sent = 0;
    for (int c = 0; c < cycles; c++) begin
      start     = (c == 0);
      stop      = (c == stop_c);
      adc_ready = !(c >= lo_a && c <= lo_b);
      bus.s_cmd_tvalid =
        (cmd_c >= 0) && (c >= cmd_c) && !cmd_sent;
      bus.s_cmd_tdata = 24'h123456;
      #1;
      if (c == 0) check("busy_c0", busy, 0);
      if (c == 1) check("busy_c1", busy, 1);
      if (trigger_acq) trig_q.push_back(c);
      if (done) done_q.push_back(c);
      if (bus.s_cmd_tready && rdy_c < 0) begin
        rdy_c    = c;
        cmd_sent = 1;
      end
      nxt();
    end
    start            = 0;
    stop             = 0;
    adc_ready        = 1;
    bus.s_cmd_tvalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    areset             = 1;
    cfg_period         = 0;
    cfg_num_samples    = 0;
    start              = 0;
    stop               = 0;
    adc_ready          = 1;
    bus.s_cmd_tvalid   = 0;
    bus.s_cmd_tdata    = 0;
    bus.m_axis_tready  = 0;
    repeat (3) nxt();
    #1;
    chk_zero("rst0");
    areset = 0;
    nxt();

    // basic run
    run(10, 4, 45, -1, -1, -1, -1);
    check("b_ntrig", trig_q.size(), 4);
    check("b_t0", trig_q[0], 10);
    check("b_t1", trig_q[1], 20);
    check("b_t2", trig_q[2], 30);
    check("b_t3", trig_q[3], 40);
    check("b_ndone", done_q.size(), 1);
    check("b_done", done_q[0], 41);
    check("b_cnt", sample_cnt, 4);
    check("b_ovr", overrun, 0);

    // overrun: slot decided in cycle 15 is skipped
    run(8, 3, 38, 15, 16, -1, -1);
    check("o_ntrig", trig_q.size(), 3);
    check("o_t0", trig_q[0], 8);
    check("o_t1", trig_q[1], 24);
    check("o_t2", trig_q[2], 32);
    check("o_done", done_q[0], 33);
    check("o_ovr", overrun, 1);
    check("o_cnt", sample_cnt, 3);

    // clamp: period 0 behaves as 2, new run clears overrun
    run(0, 3, 10, -1, -1, -1, -1);
    check("c_ntrig", trig_q.size(), 3);
    check("c_t0", trig_q[0], 2);
    check("c_t1", trig_q[1], 4);
    check("c_t2", trig_q[2], 6);
    check("c_done", done_q[0], 7);
    check("c_ovr", overrun, 0);

    // command deferral
    run(6, 2, 20, -1, -1, -1, 3);
    check("d_ntrig", trig_q.size(), 2);
    check("d_t1", trig_q[1], 12);
    check("d_done", done_q[0], 13);
    check("d_rdy", rdy_c, 13);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("d_hold_v", bus.m_axis_tvalid, 1);
      check("d_hold_d", bus.m_axis_tdata, 32'h00123456);
      nxt();
    end
    bus.m_axis_tready = 1;
    #1;
    check("d_hs_v", bus.m_axis_tvalid, 1);
    nxt();
    bus.m_axis_tready = 0;
    #1;
    check("d_w1_busy", busy, 1);
    check("d_w1_v", bus.m_axis_tvalid, 0);
    nxt();
    #1;
    check("d_w2_busy", busy, 1);
    nxt();
    #1;
    check("d_ret_busy", busy, 0);
    nxt();

    // start and command collide in IDLE
    cfg_period      = 4;
    cfg_num_samples = 1;
    trig_q.delete();
    done_q.delete();
    idle_c           = -1;
    start            = 1;
    bus.s_cmd_tvalid = 1;
    bus.s_cmd_tdata  = 24'hABCDEF;
    #1;
    check("x_srdy", bus.s_cmd_tready, 1);
    nxt();
    start             = 0;
    bus.s_cmd_tvalid  = 0;
    bus.m_axis_tready = 1;
    #1;
    check("x_mval", bus.m_axis_tvalid, 1);
    check("x_mdat", bus.m_axis_tdata, 32'h00ABCDEF);
    nxt();
    bus.m_axis_tready = 0;
    for (int c = 2; c < 16; c++) begin
      adc_ready = !(c >= 2 && c <= 5);
      #1;
      if (!busy && idle_c < 0) idle_c = c;
      if (trigger_acq) trig_q.push_back(c);
      if (done) done_q.push_back(c);
      nxt();
    end
    adc_ready = 1;
    check("x_idle", idle_c, 7);
    check("x_ntrig", trig_q.size(), 1);
    check("x_t0", trig_q[0], 11);
    check("x_done", done_q[0], 12);

    // continuous run stopped on the third slot decision
    run(5, 0, 22, -1, -1, 14, -1);
    check("s_ntrig", trig_q.size(), 2);
    check("s_t0", trig_q[0], 5);
    check("s_t1", trig_q[1], 10);
    check("s_ndone", done_q.size(), 1);
    check("s_done", done_q[0], 15);
    check("s_cnt", sample_cnt, 2);

    // reset in CMD drops the command and a pending start
    bus.s_cmd_tvalid = 1;
    bus.s_cmd_tdata  = 24'h55AA55;
    #1;
    check("r_srdy", bus.s_cmd_tready, 1);
    nxt();
    bus.s_cmd_tvalid = 0;
    start            = 1;
    #1;
    check("r_mval", bus.m_axis_tvalid, 1);
    nxt();
    start  = 0;
    areset = 1;
    nxt();
    areset = 0;
    #1;
    chk_zero("rst1");
    nxt();
    for (int k = 0; k < 6; k++) begin
      #1;
      check("r_idle_busy", busy, 0);
      check("r_idle_trig", trigger_acq, 0);
      nxt();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_acq_sequencer.md
# adc_acq_sequencer

Acquisition scheduler in the `aclk` domain that sits in front of the ADC stream block. It issues periodic `trigger_acq` pulses for a programmed number of samples. It serialises software register-write commands onto the ADC command stream so that commands never overlap an acquisition run. It also reports overruns when the ADC is not ready at a scheduled trigger slot.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of the period and sample counters.
- `CMD_WIDTH`, 24: width of the ADC register command; fixed by the ADC command format.

Ports:
- `aclk`  in  1: sole clock.
- `areset`  in  1: reset; synchronous, active-high.
- `cfg_period`  in  CNT_WIDTH: trigger period in `aclk` cycles. Values below 2 are treated as 2.
- `cfg_num_samples`  in  CNT_WIDTH: triggers per run; 0 means continuous until `stop`.
- `start`  in  1: single-cycle run request.
- `stop`  in  1: single-cycle abort.
- `s_cmd_tdata`  in  CMD_WIDTH: register command from software.
- `s_cmd_tvalid` in 1, `s_cmd_tready` out 1: command handshake.
- `m_axis_tdata`  out  32: command to the ADC, formatted as `{8'h00, cmd}`.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1: ADC command handshake.
- `adc_ready`  in  1: ADC idle status.
- `trigger_acq`  out  1: single-cycle trigger pulse, registered.
- `busy`  out  1: high when state ≠ IDLE.
- `done`  out  1: single-cycle pulse at the end of a run, whether completed or stopped.
- `overrun`  out  1: sticky; set on a skipped trigger slot, cleared when a run starts.
- `sample_cnt`  out  CNT_WIDTH: triggers issued in the current or last run.

## Operation
- States: IDLE, RUN, CMD, CMD_WAIT.
- `start_pend` flag:
  - Set by `start` in any state.
  - Cleared by `stop` or on RUN entry.
  - `stop` and `start` in the same cycle: `stop` wins.
- IDLE:
  - If `s_cmd_tvalid`: assert `s_cmd_tready` for one cycle, latch `s_cmd_tdata`, go to CMD.
  - Else if `start_pend`: latch `cfg_period` as P (clamped to ≥2) and `cfg_num_samples` as N. Clear `sample_cnt` and `overrun`. Load the period counter with P-1. Go to RUN.
  - A command and a start in the same cycle: the command wins and the start stays pending.
- RUN:
  - The period counter decrements every cycle.
  - At 0 (the trigger slot) the counter reloads P-1.
    - If `adc_ready`: pulse `trigger_acq` and increment `sample_cnt`.
    - Else: no trigger, `sample_cnt` unchanged, set `overrun`.
  - If N≠0 and the incremented `sample_cnt` equals N: pulse `done`, go to IDLE.
  - `stop`: go to IDLE next cycle and pulse `done`. A trigger slot coinciding with `stop` is suppressed, including the final one.
  - `s_cmd_tready` is held 0 for the whole run; commands wait.
- CMD:
  - `m_axis_tvalid`=1; data is held stable until `m_axis_tready`.
  - On handshake, go to CMD_WAIT.
  - `stop` has no effect in CMD or CMD_WAIT.
- CMD_WAIT:
  - Ignore `adc_ready` for 2 guard cycles, covering the ADC status update latency.
  - After the guard, return to IDLE on the first cycle with `adc_ready`=1.
- `sample_cnt` saturates at all-ones and does not wrap; this only matters in continuous mode.
- `areset` mid-operation: the next cycle is IDLE and any in-flight command is dropped, with `m_axis_tvalid` low.

## Timing
- Reset values:
  - State IDLE, `start_pend`=0.
  - All outputs 0: `trigger_acq`, `busy`, `done`, `overrun`, `sample_cnt`, `s_cmd_tready`, `m_axis_tvalid`, `m_axis_tdata`.
- Trigger timing: with `start` sampled in IDLE at cycle t, RUN is entered at t+1 and `trigger_acq` is high at t+P, t+2P, …
- `done`: high in the cycle after the final trigger, i.e. the IDLE entry cycle, or the cycle after `stop`.
- Command latency:
  - `s_cmd` accepted at cycle t in IDLE.
  - `m_axis_tvalid` high from t+1.
  - Earliest return to IDLE is 3 cycles after the `m_axis` handshake.
- `busy` follows the registered state: it asserts the cycle after IDLE is left.

## Structure
- `adc_seq_pkg`:
  - `seq_state_t` enum (IDLE, RUN, CMD, CMD_WAIT).
  - `MIN_PERIOD=2`.
  - `CMD_GUARD_CYCLES=2`.
  - `cmd_word()` function that zero-extends 24 bits to 32.
- Sub-module `adc_seq_timer`: a loadable down-counter with a `tick` output at zero and auto-reload. The FSM and counters live in the top module.

## Test plan
- Basic run:
  - Stimulus: P=10, N=4, `start` at cycle 0, `adc_ready`=1.
  - Response: triggers at cycles 10, 20, 30, 40. `done` at 41. `sample_cnt`=4. `overrun`=0.
- Overrun:
  - Stimulus: P=8, N=3, `adc_ready` low over cycle 16.
  - Response: no trigger at 16. Triggers at 8, 24, 32. `overrun`=1. `done` after 32.
- Command deferral:
  - Stimulus: command 0x123456 presented during a run with N=2.
  - Response: `s_cmd_tready` stays 0 until `done`. Then `m_axis_tdata`=0x00123456 with `m_axis_tvalid`=1. `m_axis_tready` delayed 5 cycles and data held stable.
- Start/command collision:
  - Stimulus: `start` and `s_cmd_tvalid` in the same IDLE cycle; `adc_ready` drops for 4 cycles after the handshake.
  - Response: command issued first. RUN entered only after `adc_ready` returns.
- Stop/reset:
  - Stimulus: continuous run (N=0, P=5); `stop` coinciding with the third trigger slot; then `areset` during CMD.
  - Response: 2 triggers, `done` once. After reset all outputs are 0 and state is IDLE.
- Clamp:
  - Stimulus: P=0, N=3.
  - Response: triggers every 2 cycles.
